mux4_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares one downstream port among four

---
 rtl/mux4_rr_arbiter_if.sv | 38 +++
 rtl/mux4_rr_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Handshake and control bundle between four requesters, the round-robin
// arbiter and the downstream port. The arbiter uses the slave view; the
// requester/downstream side uses the master view.
interface mux4_rr_arbiter_if;
  logic [3:0] req_valid;
  logic [3:0] req_last;
  logic [3:0] req_ready;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  modport master (
    output req_valid,
    output req_last,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  sel,
    input  grant,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req_valid,
    input  req_last,
    input  out_ready,
    output req_ready,
    output out_valid,
    output sel,
    output grant,
    output busy,
    output timeout
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one downstream port.
// A grant is held for a whole burst (ended by req_last) and drives the
// select of an external 4:1 datapath mux. A watchdog releases a requester
// that stops presenting beats mid-burst. sel keeps its last value while
// idle so the mux output does not glitch between bursts.
module mux4_rr_arbiter #(
  parameter int unsigned TIMEOUT = 16,  // idle cycles tolerated mid-burst, 0 disables
  parameter int unsigned CNT_W   = 5    // watchdog width, 2**CNT_W must exceed TIMEOUT
) (
  input logic               clk,
  input logic               reset,
  mux4_rr_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] WDOG_MAX    = {CNT_W{1'b1}};
  localparam bit               WDOG_EN     = (TIMEOUT != 0);

  // Registered state
  state_t           state;
  logic [1:0]       ptr;          // index of the last requester served
  logic [1:0]       cur_sel;
  logic [3:0]       cur_grant;
  logic             cur_busy;
  logic             cur_timeout;
  logic [CNT_W-1:0] wdog;

  // Next-state values
  state_t           state_nxt;
  logic [1:0]       ptr_nxt;
  logic [1:0]       sel_nxt;
  logic [3:0]       grant_nxt;
  logic             busy_nxt;
  logic             timeout_nxt;
  logic [CNT_W-1:0] wdog_nxt;

  // Helpers for the search and the watchdog
  logic             found;
  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             handshake;
  logic [CNT_W-1:0] wdog_inc;

  // Next-state logic: round-robin search in IDLE, burst tracking and watchdog in GRANT
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    sel_nxt     = cur_sel;
    grant_nxt   = cur_grant;
    busy_nxt    = cur_busy;
    timeout_nxt = 1'b0;
    wdog_nxt    = wdog;
    found       = 1'b0;
    pick        = ptr;
    idx         = ptr;
    handshake   = 1'b0;
    wdog_inc    = wdog;

    case (state)
      IDLE: begin
        wdog_nxt = {CNT_W{1'b0}};
        // Search starts just past the last winner so it loses priority.
        for (int k = 1; k <= 4; k++) begin
          idx = ptr + 2'(k);
          if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            pick  = idx;
          end else begin
            found = found;
          end
        end
        if (found) begin
          state_nxt = GRANT;
          sel_nxt   = pick;
          grant_nxt = 4'b0001 << pick;
          busy_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end

      GRANT: begin
        handshake = bus.req_valid[cur_sel] & bus.out_ready;
        if (wdog != WDOG_MAX) begin
          wdog_inc = wdog + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          wdog_inc = wdog;
        end

        if (handshake && bus.req_last[cur_sel]) begin
          // Burst complete: release and give the others priority.
          state_nxt = IDLE;
          ptr_nxt   = cur_sel;
          grant_nxt = 4'b0000;
          busy_nxt  = 1'b0;
          wdog_nxt  = {CNT_W{1'b0}};
        end else if (handshake) begin
          wdog_nxt = {CNT_W{1'b0}};
        end else if (!bus.req_valid[cur_sel]) begin
          // Requester stalled mid-burst; a downstream stall does not count.
          wdog_nxt = wdog_inc;
          if (WDOG_EN && (wdog_inc == TIMEOUT_CNT)) begin
            state_nxt   = IDLE;
            ptr_nxt     = cur_sel;
            grant_nxt   = 4'b0000;
            busy_nxt    = 1'b0;
            timeout_nxt = 1'b1;
            wdog_nxt    = {CNT_W{1'b0}};
          end else begin
            timeout_nxt = 1'b0;
          end
        end else begin
          wdog_nxt = wdog;
        end
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0000;
        busy_nxt  = 1'b0;
        wdog_nxt  = {CNT_W{1'b0}};
      end
    endcase
  end

  // State register with synchronous reset; ptr=3 makes requester 0 first after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= 2'd3;
      cur_sel     <= 2'd0;
      cur_grant   <= 4'b0000;
      cur_busy    <= 1'b0;
      cur_timeout <= 1'b0;
      wdog        <= {CNT_W{1'b0}};
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      cur_sel     <= sel_nxt;
      cur_grant   <= grant_nxt;
      cur_busy    <= busy_nxt;
      cur_timeout <= timeout_nxt;
      wdog        <= wdog_nxt;
    end
  end

  // Beat handshake: only the granted requester sees out_ready, and only in GRANT
  always_comb begin
    bus.out_valid = 1'b0;
    bus.req_ready = 4'b0000;
    if (state == GRANT) begin
      bus.out_valid = bus.req_valid[cur_sel];
      if (bus.out_ready) begin
        bus.req_ready = 4'b0001 << cur_sel;
      end else begin
        bus.req_ready = 4'b0000;
      end
    end else begin
      bus.out_valid = 1'b0;
      bus.req_ready = 4'b0000;
    end
  end

  assign bus.sel     = cur_sel;
  assign bus.grant   = cur_grant;
  assign bus.busy    = cur_busy;
  assign bus.timeout = cur_timeout;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus randomized requesters,
// all checked cycle by cycle against a behavioural model of the arbiter.
module tb_mux4_rr_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: who owns the port (-1 = nobody), last winner, idle count
  int m_owner = -1;
  int m_last  = 3;
  int m_sel   = 0;
  int m_idle  = 0;
  bit m_tout  = 1'b0;
  int m_wait [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
  endtask

  function automatic logic [3:0] onehot(input int i);
    if (i < 0) return 4'b0000;
    return 4'b0001 << i;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 3; m_sel = 0; m_idle = 0; m_tout = 1'b0;
    for (int i = 0; i < 4; i++) m_wait[i] = 0;
  endtask

  // One clock cycle: drive, check handshake outputs, advance model, check registered outputs
  task automatic cycle(input logic [3:0] rv, input logic [3:0] rl, input logic ordy, input logic rst);
    bit exp_ov;
    int j;
    @(negedge clk);
    reset = rst;
    bus.req_valid = rv;
    bus.req_last  = rl;
    bus.out_ready = ordy;
    #1;
    exp_ov = 1'b0;
    if (m_owner >= 0) exp_ov = rv[m_owner];
    check("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_ov});
    check("req_ready", {28'b0, bus.req_ready}, (m_owner >= 0 && ordy) ? {28'b0, onehot(m_owner)} : 32'd0);

    if (rst) begin
      model_reset();
    end else begin
      m_tout = 1'b0;
      if (m_owner < 0) begin
        m_idle = 0;
        j = -1;
        for (int k = 1; k <= 4; k++)
          if (j < 0 && rv[(m_last + k) % 4]) j = (m_last + k) % 4;
        if (j >= 0) begin
          for (int i = 0; i < 4; i++) begin
            if (i != j && rv[i]) begin
              m_wait[i]++;
              check("fairness", {31'b0, m_wait[i] <= 3}, 32'd1);
            end else m_wait[i] = 0;
          end
          m_owner = j;
          m_sel   = j;
        end
      end else if (rv[m_owner] && ordy && rl[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_idle = 0;
      end else if (rv[m_owner] && ordy) begin
        m_idle = 0;
      end else if (!rv[m_owner]) begin
        m_idle++;
        if (TO != 0 && m_idle >= TO) begin
          m_tout = 1'b1; m_last = m_owner; m_owner = -1; m_idle = 0;
        end
      end
    end

    @(posedge clk);
    #1;
    check("grant",   {28'b0, bus.grant},   {28'b0, onehot(m_owner)});
    check("sel",     {30'b0, bus.sel},     32'(m_sel));
    check("busy",    {31'b0, bus.busy},    {31'b0, m_owner >= 0});
    check("timeout", {31'b0, bus.timeout}, {31'b0, m_tout});
  endtask

  // Randomized requester state
  bit act [4];
  int left [4];
  int stall [4];

  logic [3:0] seq_grant [9];

  initial begin
    logic [3:0] rv, rl;
    logic ordy, rst;
    int prev_owner;

    // Initial reset and reset values
    reset = 1'b1;
    bus.req_valid = 4'b0000; bus.req_last = 4'b0000; bus.out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    check("rst_grant",   {28'b0, bus.grant},     32'd0);
    check("rst_sel",     {30'b0, bus.sel},       32'd0);
    check("rst_busy",    {31'b0, bus.busy},      32'd0);
    check("rst_timeout", {31'b0, bus.timeout},   32'd0);
    check("rst_ovalid",  {31'b0, bus.out_valid}, 32'd0);

    // All four requesting single-beat bursts: 0,1,2,3,0 with a bubble between
    seq_grant = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    for (int c = 0; c < 9; c++) begin
      cycle(4'b1111, 4'b1111, 1'b1, 1'b0);
      check("rr_seq", {28'b0, bus.grant}, {28'b0, seq_grant[c]});
    end
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

    // Requester 2, 3-beat burst, downstream stall on the second grant cycle
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0100, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
    check("burst_hold", {28'b0, bus.grant}, 32'h4);
    cycle(4'b0100, 4'b0100, 1'b1, 1'b0);
    check("burst_end", {28'b0, bus.grant}, 32'h0);

    // Watchdog: requester 1 sends one non-last beat then goes quiet; 3 waits
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    cycle(4'b0010, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0010, 4'b0000, 1'b1, 1'b0);
    for (int c = 0; c < TO; c++) cycle(4'b1000, 4'b0000, 1'b1, 1'b0);
    check("wdog_pulse", {31'b0, bus.timeout}, 32'd1);
    check("wdog_rel",   {28'b0, bus.grant},   32'd0);
    cycle(4'b1000, 4'b0000, 1'b1, 1'b0);
    check("wdog_next", {28'b0, bus.grant}, 32'h8);

    // Reset mid-burst while requester 3 holds the grant
    cycle(4'b1000, 4'b0000, 1'b1, 1'b0);
    cycle(4'b1000, 4'b0000, 1'b1, 1'b1);
    check("mid_rst_grant", {28'b0, bus.grant},     32'd0);
    check("mid_rst_sel",   {30'b0, bus.sel},       32'd0);
    check("mid_rst_ov",    {31'b0, bus.out_valid}, 32'd0);
    cycle(4'b1001, 4'b1001, 1'b1, 1'b0);
    check("after_rst", {28'b0, bus.grant}, 32'h1);
    cycle(4'b1000, 4'b1000, 1'b1, 1'b0);

    // After a burst from 1 (ptr=1), 0 and 1 pending: 0 wins, then 1
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    cycle(4'b0010, 4'b0010, 1'b1, 1'b0);
    cycle(4'b0010, 4'b0010, 1'b1, 1'b0);
    cycle(4'b0011, 4'b0011, 1'b1, 1'b0);
    check("ptr_wrap0", {28'b0, bus.grant}, 32'h1);
    cycle(4'b0011, 4'b0011, 1'b1, 1'b0);
    cycle(4'b0010, 4'b0010, 1'b1, 1'b0);
    check("ptr_wrap1", {28'b0, bus.grant}, 32'h2);

    // Randomized traffic
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin act[i] = 1'b0; left[i] = 0; stall[i] = 0; end
    for (int c = 0; c < 10000; c++) begin
      rst  = ($urandom_range(0, 999) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      rv = 4'b0000; rl = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (!act[i] && $urandom_range(0, 3) == 0) begin
          act[i] = 1'b1; left[i] = $urandom_range(1, 4);
        end
        if (m_owner != i) stall[i] = 0;
        else if (stall[i] == 0 && $urandom_range(0, 15) == 0) stall[i] = $urandom_range(1, 6);
        if (act[i]) begin
          if (stall[i] > 0) stall[i]--;
          else rv[i] = 1'b1;
          rl[i] = (left[i] == 1);
        end
      end
      prev_owner = m_owner;
      cycle(rv, rl, ordy, rst);
      if (rst) begin
        for (int i = 0; i < 4; i++) begin act[i] = 1'b0; stall[i] = 0; end
      end else if (prev_owner >= 0) begin
        if (rv[prev_owner] && ordy) begin
          left[prev_owner]--;
          if (left[prev_owner] == 0) act[prev_owner] = 1'b0;
        end
        if (m_tout) begin act[prev_owner] = 1'b0; stall[prev_owner] = 0; end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
